// File: rtl/score_display_pkg.sv
// Shared constants for the score display: glyph codes, active-low segment
// patterns ({g,f,e,d,c,b,a}), winner encoding and the idle game state.
package score_display_pkg;

   localparam int unsigned SCORE_W      = 3;
   localparam int unsigned STATE_W      = 3;
   localparam int unsigned DIGIT_IDX_W  = 2;
   localparam int unsigned GLYPH_CODE_W = 4;
   localparam int unsigned SEG_W        = 7;
   localparam int unsigned AN_W         = 4;

   // Active-low segment patterns
   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_P     = 7'h0C;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Glyph codes for non-numeric symbols; 0-7 are the digits themselves
   localparam logic [GLYPH_CODE_W-1:0] CODE_P     = 4'hA;
   localparam logic [GLYPH_CODE_W-1:0] CODE_DASH  = 4'hB;
   localparam logic [GLYPH_CODE_W-1:0] CODE_BLANK = 4'hF;

   localparam logic [STATE_W-1:0] STATE_IDLE = 3'b000;

   typedef enum logic [1:0] {NONE, P1, P2, TIE} winner_e;

   // Glyph code of a numeric score
   function automatic logic [GLYPH_CODE_W-1:0] score_code(input logic [SCORE_W-1:0] s);
      return {1'b0, s};
   endfunction

endpackage

// File: rtl/score_display_seg7_glyph.sv
// Combinational glyph decoder: 4-bit glyph code to active-low segments.
module seg7_glyph
   import score_display_pkg::*;
(
   input  logic [GLYPH_CODE_W-1:0] code,
   output logic [SEG_W-1:0]        seg_c
);

   // Map each code to its segment pattern; unknown codes are blank
   always_comb begin
      seg_c = SEG_BLANK;
      case (code)
         4'h0:       seg_c = SEG_0;
         4'h1:       seg_c = SEG_1;
         4'h2:       seg_c = SEG_2;
         4'h3:       seg_c = SEG_3;
         4'h4:       seg_c = SEG_4;
         4'h5:       seg_c = SEG_5;
         4'h6:       seg_c = SEG_6;
         4'h7:       seg_c = SEG_7;
         CODE_P:     seg_c = SEG_P;
         CODE_DASH:  seg_c = SEG_DASH;
         default:    seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display with score-change flash and winner
// latch. Define SCORE_DISPLAY_BLINK_EN to blink the winner glyphs.
module score_display
   import score_display_pkg::*;
#(
   parameter int unsigned DIGIT_MS = 1,
   parameter int unsigned BLINK_MS = 500,
   parameter int unsigned FLASH_MS = 250
) (
   input  logic               clk_1ms,
   input  logic               reset,
   input  logic [SCORE_W-1:0] p1_score,
   input  logic [SCORE_W-1:0] p2_score,
   input  logic               overflow1,
   input  logic               overflow2,
   input  logic [STATE_W-1:0] state,
   output logic [AN_W-1:0]    an,
   output logic [SEG_W-1:0]   seg,
   output logic               dp
);

   localparam int unsigned SCAN_TMR_W = 4;
   localparam int unsigned FLASH_W    = $clog2(FLASH_MS + 1);

   logic [DIGIT_IDX_W-1:0]  scan_idx_q, scan_idx_d;
   logic [SCAN_TMR_W-1:0]   scan_tmr_q, scan_tmr_d;
   logic [SCORE_W-1:0]      p1_q, p1_d, p2_q, p2_d;
   winner_e                 winner_q, winner_d;
   logic [FLASH_W-1:0]      flash1_q, flash1_d, flash2_q, flash2_d;
   logic [AN_W-1:0]         an_q, an_d;
   logic [SEG_W-1:0]        seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [GLYPH_CODE_W-1:0] glyph_code_c;
   logic [SEG_W-1:0]        glyph_seg_c;
   logic                    blink_on_c;

   // Scan timing, score sampling, winner latch and flash counters
   always_comb begin
      p1_d       = p1_score;
      p2_d       = p2_score;
      scan_tmr_d = scan_tmr_q + SCAN_TMR_W'(1);
      scan_idx_d = scan_idx_q;
      if (scan_tmr_q >= SCAN_TMR_W'(DIGIT_MS - 1)) begin
         scan_tmr_d = '0;
         scan_idx_d = scan_idx_q - DIGIT_IDX_W'(1);
      end

      winner_d = winner_q;
      if (state == STATE_IDLE) begin
         winner_d = NONE;
      end else if (winner_q == NONE) begin
         if (overflow1 && overflow2) winner_d = TIE;
         else if (overflow1)         winner_d = P1;
         else if (overflow2)         winner_d = P2;
      end

      flash1_d = (flash1_q != '0) ? flash1_q - FLASH_W'(1) : '0;
      flash2_d = (flash2_q != '0) ? flash2_q - FLASH_W'(1) : '0;
      if (p1_d != p1_q) flash1_d = FLASH_W'(FLASH_MS);
      if (p2_d != p2_q) flash2_d = FLASH_W'(FLASH_MS);
      if (winner_d != NONE) begin
         flash1_d = '0;
         flash2_d = '0;
      end
   end

`ifdef SCORE_DISPLAY_BLINK_EN
   localparam int unsigned BLINK_W = $clog2(BLINK_MS + 1);

   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_on_q, blink_on_d;

   // Blink phase: restarts on-phase at the latch tick, toggles every BLINK_MS ticks
   always_comb begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      if (winner_d != NONE && winner_q != NONE) begin
         blink_on_d = blink_on_q;
         if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
            blink_on_d = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end
   end

   // Blink state registers
   always_ff @(posedge clk_1ms or negedge reset) begin
      if (!reset) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
      end
   end

   assign blink_on_c = blink_on_d;
`else
   // Steady winner display; a zero half-period is not a meaningful blink setting
   assign blink_on_c = (BLINK_MS != 0);
`endif

   // Select the glyph, anode and decimal point for the digit being scanned
   always_comb begin
      glyph_code_c = CODE_BLANK;
      dp_d         = 1'b1;
      an_d         = ~(AN_W'(1) << scan_idx_q);
      if (winner_d == NONE) begin
         case (scan_idx_q)
            2'd3: begin
               glyph_code_c = score_code(p1_d);
               dp_d         = (flash1_d == '0);
            end
            2'd2:    glyph_code_c = CODE_DASH;
            2'd1:    glyph_code_c = CODE_BLANK;
            default: begin
               glyph_code_c = score_code(p2_d);
               dp_d         = (flash2_d == '0);
            end
         endcase
      end else if (!blink_on_c) begin
         an_d = '1;
      end else begin
         case (winner_d)
            P1: begin
               if (scan_idx_q == 2'd3)      glyph_code_c = CODE_P;
               else if (scan_idx_q == 2'd2) glyph_code_c = score_code(3'd1);
            end
            P2: begin
               if (scan_idx_q == 2'd3)      glyph_code_c = CODE_P;
               else if (scan_idx_q == 2'd2) glyph_code_c = score_code(3'd2);
            end
            default: glyph_code_c = CODE_DASH;
         endcase
      end
   end

   seg7_glyph u_glyph (
      .code  (glyph_code_c),
      .seg_c (glyph_seg_c)
   );

   assign seg_d = glyph_seg_c;

   // State and output registers
   always_ff @(posedge clk_1ms or negedge reset) begin
      if (!reset) begin
         scan_idx_q <= 2'd3;
         scan_tmr_q <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         winner_q   <= NONE;
         flash1_q   <= '0;
         flash2_q   <= '0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         scan_idx_q <= scan_idx_d;
         scan_tmr_q <= scan_tmr_d;
         p1_q       <= p1_d;
         p2_q       <= p2_d;
         winner_q   <= winner_d;
         flash1_q   <= flash1_d;
         flash2_q   <= flash2_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display against a tick-level reference model.
// Honours SCORE_DISPLAY_BLINK_EN the same way as the design.
module tb_score_display;

   localparam int DIGIT_MS = 1;
   localparam int BLINK_MS = 500;
   localparam int FLASH_MS = 250;
   localparam int NEVER    = -1000000;

   logic       clk_1ms = 1'b0;
   logic       reset   = 1'b0;
   logic [2:0] p1_score, p2_score, state;
   logic       overflow1, overflow2;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int mt, m_p1, m_p2, m_win, latch_t, chg1_t, chg2_t;

   initial forever #5 clk_1ms = ~clk_1ms;

   score_display #(
      .DIGIT_MS (DIGIT_MS),
      .BLINK_MS (BLINK_MS),
      .FLASH_MS (FLASH_MS)
   ) dut (
      .clk_1ms   (clk_1ms),
      .reset     (reset),
      .p1_score  (p1_score),
      .p2_score  (p2_score),
      .overflow1 (overflow1),
      .overflow2 (overflow2),
      .state     (state),
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (tick %0d, t=%0t)", tag, got, exp, mt, $time);
      end
   endtask

   // glyph index: 0-7 digits, 8 'P', 9 dash, anything else blank
   function automatic logic [6:0] seg_of(input int g);
      logic [6:0] lit;
      case (g)
         0: lit = 7'b0111111;
         1: lit = 7'b0000110;
         2: lit = 7'b1011011;
         3: lit = 7'b1001111;
         4: lit = 7'b1100110;
         5: lit = 7'b1101101;
         6: lit = 7'b1111101;
         7: lit = 7'b0000111;
         8: lit = 7'b1110011;
         9: lit = 7'b1000000;
         default: lit = 7'b0000000;
      endcase
      return ~lit;
   endfunction

   task automatic model_reset();
      mt = 0; m_p1 = 0; m_p2 = 0; m_win = 0; latch_t = 0;
      chg1_t = NEVER; chg2_t = NEVER;
   endtask

   // apply one tick of the rules to the sampled inputs
   task automatic model_tick();
      mt++;
      if (int'(p1_score) != m_p1) chg1_t = mt;
      if (int'(p2_score) != m_p2) chg2_t = mt;
      m_p1 = int'(p1_score);
      m_p2 = int'(p2_score);
      if (state == 3'b000) m_win = 0;
      else if (m_win == 0 && (overflow1 || overflow2)) begin
         m_win   = (overflow1 && overflow2) ? 3 : (overflow1 ? 1 : 2);
         latch_t = mt;
      end
      if (m_win != 0) begin
         chg1_t = NEVER;
         chg2_t = NEVER;
      end
   endtask

   task automatic expect_outputs();
      int d, g;
      logic [3:0] e_an;
      logic e_dp;
      d    = 3 - ((mt - 1) / DIGIT_MS) % 4;
      e_an = ~(4'b0001 << d);
      e_dp = 1'b1;
      g    = 10;
      if (m_win == 0) begin
         case (d)
            3: g = m_p1;
            2: g = 9;
            1: g = 10;
            default: g = m_p2;
         endcase
         if (d == 3 && (mt - chg1_t) < FLASH_MS) e_dp = 1'b0;
         if (d == 0 && (mt - chg2_t) < FLASH_MS) e_dp = 1'b0;
      end else begin
         if (m_win == 3) g = 9;
         else if (d == 3) g = 8;
         else if (d == 2) g = m_win;
`ifdef SCORE_DISPLAY_BLINK_EN
         if (((mt - latch_t) / BLINK_MS) % 2 == 1) begin
            e_an = 4'hF;
            g    = 10;
         end
`endif
      end
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(seg_of(g)));
      check("dp", 32'(dp), 32'(e_dp));
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk_1ms);
         model_tick();
         @(negedge clk_1ms);
         expect_outputs();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an"}, 32'(an), 32'hF);
      check({tag, "_seg"}, 32'(seg), 32'h7F);
      check({tag, "_dp"}, 32'(dp), 32'h1);
   endtask

   // assert reset between edges and expect outputs to drop without a clock
   task automatic async_reset(input string tag);
      @(posedge clk_1ms);
      #3 reset = 1'b0;
      #1 check_reset_outputs({tag, "_async"});
      @(posedge clk_1ms);
      #1 check_reset_outputs({tag, "_held"});
      @(negedge clk_1ms);
      model_reset();
      reset = 1'b1;
   endtask

   initial begin
      p1_score = 3'd3; p2_score = 3'd5; state = 3'b011;
      overflow1 = 1'b0; overflow2 = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_1ms);
      check_reset_outputs("reset");
      reset = 1'b1;
      step(8);

      // flash on score changes, including reload while running
      step(260);
      p1_score = 3'd2; step(300);
      p1_score = 3'd3; step(100);
      p1_score = 3'd4; step(200);
      p2_score = 3'd6; step(10);

      // player 1 wins, later overflows do not alter the latch
      overflow1 = 1'b1; step(1); overflow1 = 1'b0; step(1100);
      overflow2 = 1'b1; step(3); overflow2 = 1'b0; step(5);

      // idle clears the latch and masks overflow
      state = 3'b000; p1_score = 3'd1; step(4);
      overflow1 = 1'b1; overflow2 = 1'b1; step(4);
      overflow1 = 1'b0; overflow2 = 1'b0;

      // tie, then player 2
      state = 3'b010; overflow1 = 1'b1; overflow2 = 1'b1; step(1);
      overflow1 = 1'b0; overflow2 = 1'b0; step(20);
      state = 3'b000; step(2);
      state = 3'b001; overflow2 = 1'b1; step(1); overflow2 = 1'b0; step(600);
      state = 3'b000; step(2); state = 3'b011;

      // asynchronous reset mid-flash and mid-blink
      p1_score = 3'd5; step(5);
      async_reset("flash");
      step(6);
      overflow1 = 1'b1; step(1); overflow1 = 1'b0; step(700);
      async_reset("blink");
      step(4);

      // randomized play
      repeat (2500) begin
         if ($urandom_range(0, 19) == 0) p1_score = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) p2_score = 3'($urandom_range(0, 7));
         overflow1 = ($urandom_range(0, 99) < 2);
         overflow2 = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 49) == 0) state = 3'b000;
         else if ($urandom_range(0, 9) == 0) state = 3'($urandom_range(1, 7));
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
